// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with ALU, PC+imm adder, MEM/WB operand forwarding
// and an iterative multiply/divide unit for the RV M extension.
// Ports:
//   clk, rst (async, active low)
//   in_valid, flush, is_md                  instruction qualifiers
//   rs1, rs2, rd_mem, rd_wb, regwrite_*     forwarding controls
//   pc, read_data1/2, immediate             operands
//   wb_data_mem, write_data_wb              forwarded values
//   aluinputpc, alusrc, inst30, funct3, aluop  ALU decode
//   read_data2_forwarded, sum, alu_branch, alu_result, result_valid, ex_stall
module ex_stage_md #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned RS_W   = 5,
  parameter int unsigned MD_BPC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            flush,
  input  logic            is_md,
  input  logic [RS_W-1:0] rs1,
  input  logic [RS_W-1:0] rs2,
  input  logic [PC_W-1:0] pc,
  input  logic [XLEN-1:0] read_data1,
  input  logic [XLEN-1:0] read_data2,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] wb_data_mem,
  input  logic [XLEN-1:0] write_data_wb,
  input  logic [RS_W-1:0] rd_mem,
  input  logic [RS_W-1:0] rd_wb,
  input  logic            regwrite_mem,
  input  logic            regwrite_wb,
  input  logic            aluinputpc,
  input  logic            alusrc,
  input  logic            inst30,
  input  logic [2:0]      funct3,
  input  logic [1:0]      aluop,
  output logic [XLEN-1:0] read_data2_forwarded,
  output logic [PC_W-1:0] sum,
  output logic            alu_branch,
  output logic [XLEN-1:0] alu_result,
  output logic            result_valid,
  output logic            ex_stall
);
  localparam int unsigned N_ITER = XLEN / MD_BPC;
  localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam int unsigned SH_W   = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [XLEN-1:0]   hi, hi_nxt, lo, lo_nxt, dsr, dsr_nxt;
  logic [2:0]        md_f3, md_f3_nxt;
  logic              neg_a, neg_a_nxt, neg_b, neg_b_nxt;

  logic [XLEN-1:0]   fwd1, fwd2, op1, op2, alu_out, md_res;
  logic [XLEN-1:0]   st_hi, st_lo;
  logic [XLEN:0]     st_t;
  logic [2*XLEN-1:0] prod;
  logic [SH_W-1:0]   shamt;
  logic              br_cond, accept, a_sgn, b_sgn, div_zero, div_ovf;

  // Operand forwarding, MEM has priority over WB; x0 is never forwarded
  always_comb begin
    fwd1 = read_data1;
    if (regwrite_mem && rd_mem != '0 && rd_mem == rs1)     fwd1 = wb_data_mem;
    else if (regwrite_wb && rd_wb != '0 && rd_wb == rs1)   fwd1 = write_data_wb;
    fwd2 = read_data2;
    if (regwrite_mem && rd_mem != '0 && rd_mem == rs2)     fwd2 = wb_data_mem;
    else if (regwrite_wb && rd_wb != '0 && rd_wb == rs2)   fwd2 = write_data_wb;
  end

  // Base ALU and branch comparator
  always_comb begin
    op1     = aluinputpc ? XLEN'(pc) : fwd1;
    op2     = alusrc ? immediate : fwd2;
    shamt   = op2[SH_W-1:0];
    alu_out = '0;
    case (aluop)
      2'b00:   alu_out = op1 + op2;
      2'b01:   alu_out = op1 - op2;
      default: begin
        case (funct3)
          3'b000:  alu_out = (aluop == 2'b10 && inst30) ? op1 - op2 : op1 + op2;
          3'b001:  alu_out = op1 << shamt;
          3'b010:  alu_out = XLEN'($signed(op1) < $signed(op2));
          3'b011:  alu_out = XLEN'(op1 < op2);
          3'b100:  alu_out = op1 ^ op2;
          3'b101:  alu_out = inst30 ? XLEN'($signed(op1) >>> shamt) : op1 >> shamt;
          3'b110:  alu_out = op1 | op2;
          default: alu_out = op1 & op2;
        endcase
      end
    endcase
    case (funct3)
      3'b000:  br_cond = (op1 == op2);
      3'b001:  br_cond = (op1 != op2);
      3'b100:  br_cond = ($signed(op1) < $signed(op2));
      3'b101:  br_cond = ($signed(op1) >= $signed(op2));
      3'b110:  br_cond = (op1 < op2);
      3'b111:  br_cond = (op1 >= op2);
      default: br_cond = 1'b0;
    endcase
  end

  // Accept decode: operand signedness and divide special cases
  always_comb begin
    accept   = (state == IDLE) && in_valid && is_md && !flush;
    a_sgn    = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    b_sgn    = a_sgn && (funct3 != 3'b010);
    div_zero = funct3[2] && (fwd2 == '0);
    div_ovf  = funct3[2] && !funct3[0] && (fwd1 == {1'b1, {(XLEN-1){1'b0}}}) && (&fwd2);
  end

  // MD_BPC shift-add (multiply) or restoring-subtract (divide) steps per cycle.
  // hi/lo hold the running product, or remainder/quotient with the dividend
  // shifting out of lo's MSB.
  always_comb begin
    st_hi = hi;
    st_lo = lo;
    st_t  = '0;
    for (int i = 0; i < MD_BPC; i++) begin
      if (md_f3[2]) begin
        st_t = {st_hi, st_lo[XLEN-1]};
        if (st_t >= {1'b0, dsr}) begin
          st_t  = st_t - {1'b0, dsr};
          st_lo = {st_lo[XLEN-2:0], 1'b1};
        end else begin
          st_lo = {st_lo[XLEN-2:0], 1'b0};
        end
        st_hi = st_t[XLEN-1:0];
      end else begin
        st_t  = {1'b0, st_hi} + (st_lo[0] ? {1'b0, dsr} : '0);
        st_lo = {st_t[0], st_lo[XLEN-1:1]};
        st_hi = st_t[XLEN:1];
      end
    end
  end

  // Sign fix-up of the magnitude result
  always_comb begin
    prod = {hi, lo};
    if (neg_a ^ neg_b) prod = -prod;
    case (md_f3)
      3'b000:         md_res = prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         md_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: md_res = (neg_a ^ neg_b) ? -lo : lo;
      default:        md_res = neg_a ? -hi : hi;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      dsr   <= '0;
      md_f3 <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      dsr   <= dsr_nxt;
      md_f3 <= md_f3_nxt;
      neg_a <= neg_a_nxt;
      neg_b <= neg_b_nxt;
    end
  end

  // Next state; special divides preload hi/lo so the DONE fix-up yields the
  // architectural answer with both sign flags cleared
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi;
    lo_nxt    = lo;
    dsr_nxt   = dsr;
    md_f3_nxt = md_f3;
    neg_a_nxt = neg_a;
    neg_b_nxt = neg_b;
    case (state)
      IDLE: begin
        if (accept) begin
          md_f3_nxt = funct3;
          neg_a_nxt = a_sgn && fwd1[XLEN-1];
          neg_b_nxt = b_sgn && fwd2[XLEN-1];
          hi_nxt    = '0;
          lo_nxt    = neg_a_nxt ? -fwd1 : fwd1;
          dsr_nxt   = neg_b_nxt ? -fwd2 : fwd2;
          cnt_nxt   = CNT_W'(N_ITER - 1);
          state_nxt = BUSY;
          if (div_zero) begin
            lo_nxt    = '1;
            hi_nxt    = fwd1;
            neg_a_nxt = 1'b0;
            neg_b_nxt = 1'b0;
            state_nxt = DONE;
          end else if (div_ovf) begin
            lo_nxt    = fwd1;
            hi_nxt    = '0;
            neg_a_nxt = 1'b0;
            neg_b_nxt = 1'b0;
            state_nxt = DONE;
          end
        end
      end
      BUSY: begin
        hi_nxt  = st_hi;
        lo_nxt  = st_lo;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Outputs; everything held at zero while in reset
  always_comb begin
    read_data2_forwarded = fwd2;
    sum                  = pc + PC_W'(immediate);
    alu_branch           = (aluop == 2'b01) && !is_md && br_cond;
    alu_result           = alu_out;
    result_valid         = in_valid && !is_md;
    ex_stall             = 1'b0;
    case (state)
      IDLE: ex_stall = accept;
      BUSY: begin
        result_valid = 1'b0;
        ex_stall     = !flush;
      end
      DONE: begin
        alu_result   = md_res;
        result_valid = !flush;
      end
      default: ;
    endcase
    if (!rst) begin
      read_data2_forwarded = '0;
      sum                  = '0;
      alu_branch           = 1'b0;
      alu_result           = '0;
      result_valid         = 1'b0;
      ex_stall             = 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed checks of ex_stage_md (MD_BPC=1 main instance,
// MD_BPC=4 second instance sharing all inputs except in_valid).
module tb_ex_stage_md;
  logic        clk, rst, in_valid, in_valid4, flush, is_md;
  logic [4:0]  rs1, rs2, rd_mem, rd_wb;
  logic [31:0] pc, read_data1, read_data2, immediate, wb_data_mem, write_data_wb;
  logic        regwrite_mem, regwrite_wb, aluinputpc, alusrc, inst30;
  logic [2:0]  funct3;
  logic [1:0]  aluop;
  logic [31:0] read_data2_forwarded, alu_result, sum;
  logic        alu_branch, result_valid, ex_stall;
  logic [31:0] read_data2_forwarded4, alu_result4, sum4;
  logic        alu_branch4, result_valid4, ex_stall4;

  int errors = 0;
  int checks = 0;

  ex_stage_md #(.XLEN(32), .PC_W(32), .RS_W(5), .MD_BPC(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .is_md(is_md),
    .rs1(rs1), .rs2(rs2), .pc(pc), .read_data1(read_data1), .read_data2(read_data2),
    .immediate(immediate), .wb_data_mem(wb_data_mem), .write_data_wb(write_data_wb),
    .rd_mem(rd_mem), .rd_wb(rd_wb), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
    .aluinputpc(aluinputpc), .alusrc(alusrc), .inst30(inst30), .funct3(funct3), .aluop(aluop),
    .read_data2_forwarded(read_data2_forwarded), .sum(sum), .alu_branch(alu_branch),
    .alu_result(alu_result), .result_valid(result_valid), .ex_stall(ex_stall));

  ex_stage_md #(.XLEN(32), .PC_W(32), .RS_W(5), .MD_BPC(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .flush(flush), .is_md(is_md),
    .rs1(rs1), .rs2(rs2), .pc(pc), .read_data1(read_data1), .read_data2(read_data2),
    .immediate(immediate), .wb_data_mem(wb_data_mem), .write_data_wb(write_data_wb),
    .rd_mem(rd_mem), .rd_wb(rd_wb), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
    .aluinputpc(aluinputpc), .alusrc(alusrc), .inst30(inst30), .funct3(funct3), .aluop(aluop),
    .read_data2_forwarded(read_data2_forwarded4), .sum(sum4), .alu_branch(alu_branch4),
    .alu_result(alu_result4), .result_valid(result_valid4), .ex_stall(ex_stall4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    in_valid = 0; in_valid4 = 0; flush = 0; is_md = 0;
    rs1 = 0; rs2 = 0; rd_mem = 0; rd_wb = 0; regwrite_mem = 0; regwrite_wb = 0;
    pc = 0; read_data1 = 0; read_data2 = 0; immediate = 0; wb_data_mem = 0; write_data_wb = 0;
    aluinputpc = 0; alusrc = 0; inst30 = 0; funct3 = 0; aluop = 2'b10;
  endtask

  task automatic set_alu(input logic [1:0] aop, input logic [2:0] f3, input logic i30,
                         input logic asrc, input logic apc);
    aluop = aop; funct3 = f3; inst30 = i30; alusrc = asrc; aluinputpc = apc;
  endtask

  // Issues one M op in the current cycle (t) and waits for its result.
  // lat = cycles from t to the result_valid cycle (-1 on timeout).
  // perturb: operands come from MEM/WB forwarding and change after t.
  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit use4, input bit perturb,
                        output logic [31:0] res, output int lat, output int stalls);
    is_md = 1; funct3 = f3; aluop = 2'b10; inst30 = 0; alusrc = 0; aluinputpc = 0; flush = 0;
    rs1 = 5'd1; rs2 = 5'd2;
    if (perturb) begin
      rd_mem = 5'd1; regwrite_mem = 1; wb_data_mem = a;
      rd_wb = 5'd2; regwrite_wb = 1; write_data_wb = b;
      read_data1 = 32'h5555_5555; read_data2 = 32'h3333_3333;
    end else begin
      regwrite_mem = 0; regwrite_wb = 0; read_data1 = a; read_data2 = b;
    end
    if (use4) in_valid4 = 1; else in_valid = 1;
    res = '0; lat = -1; stalls = 0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (use4 ? ex_stall4 : ex_stall) stalls++;
      if (use4 ? result_valid4 : result_valid) begin
        lat = c;
        res = use4 ? alu_result4 : alu_result;
      end
      @(posedge clk); #1;
      if (perturb && c == 0) begin
        wb_data_mem = 32'hDEAD_BEEF; write_data_wb = 32'h0BAD_F00D;
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0; in_valid = 1; pc = 32'h100; immediate = 32'h20; read_data1 = 32'h7; read_data2 = 32'h3;
    rs2 = 5'd2;
    @(negedge clk);
    checks++; if (alu_result !== 32'h0) begin errors++; $display("FAIL reset_alu_result: got %h expected %h", alu_result, 32'h0); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b expected 0", result_valid); end
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL reset_ex_stall: got %b expected 0", ex_stall); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h expected %h", sum, 32'h0); end
    checks++; if (read_data2_forwarded !== 32'h0) begin errors++; $display("FAIL reset_fwd2: got %h expected %h", read_data2_forwarded, 32'h0); end
    @(posedge clk); #1;
    rst = 1;
    clear_inputs();
  endtask

  task automatic test_add();
    clear_inputs();
    in_valid = 1; set_alu(2'b10, 3'b000, 0, 0, 0);
    rs1 = 5'd5; rd_mem = 5'd5; regwrite_mem = 1; wb_data_mem = 32'd10; read_data1 = 32'd99;
    rs2 = 5'd6; read_data2 = 32'd3; pc = 32'h100; immediate = 32'h20;
    @(negedge clk);
    checks++; if (alu_result !== 32'd13) begin errors++; $display("FAIL add_result: got %h expected %h", alu_result, 32'd13); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", result_valid); end
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL add_stall: got %b expected 0", ex_stall); end
    checks++; if (sum !== 32'h120) begin errors++; $display("FAIL add_sum: got %h expected %h", sum, 32'h120); end
    inst30 = 1; #1;
    checks++; if (alu_result !== 32'd7) begin errors++; $display("FAIL sub_result: got %h expected %h", alu_result, 32'd7); end
    set_alu(2'b11, 3'b000, 1, 1, 0); #1;
    checks++; if (alu_result !== 32'h2A) begin errors++; $display("FAIL addi_result: got %h expected %h", alu_result, 32'h2A); end
    set_alu(2'b00, 3'b000, 0, 1, 1); #1;
    checks++; if (alu_result !== 32'h120) begin errors++; $display("FAIL auipc_result: got %h expected %h", alu_result, 32'h120); end
    @(posedge clk); #1;
  endtask

  task automatic test_alu_misc();
    clear_inputs();
    in_valid = 1; rs1 = 5'd9; rs2 = 5'd10; read_data1 = 32'hFFFF_FF00; read_data2 = 32'd4;
    set_alu(2'b10, 3'b101, 1, 0, 0); #1;
    checks++; if (alu_result !== 32'hFFFF_FFF0) begin errors++; $display("FAIL sra_result: got %h expected %h", alu_result, 32'hFFFF_FFF0); end
    inst30 = 0; #1;
    checks++; if (alu_result !== 32'h0FFF_FFF0) begin errors++; $display("FAIL srl_result: got %h expected %h", alu_result, 32'h0FFF_FFF0); end
    set_alu(2'b10, 3'b010, 0, 0, 0); #1;
    checks++; if (alu_result !== 32'd1) begin errors++; $display("FAIL slt_result: got %h expected %h", alu_result, 32'd1); end
    funct3 = 3'b011; #1;
    checks++; if (alu_result !== 32'd0) begin errors++; $display("FAIL sltu_result: got %h expected %h", alu_result, 32'd0); end
    set_alu(2'b01, 3'b100, 0, 0, 0); #1;
    checks++; if (alu_branch !== 1'b1) begin errors++; $display("FAIL blt_branch: got %b expected 1", alu_branch); end
    funct3 = 3'b110; #1;
    checks++; if (alu_branch !== 1'b0) begin errors++; $display("FAIL bltu_branch: got %b expected 0", alu_branch); end
    // BEQ condition true, but an M op must never branch
    in_valid = 0; is_md = 1; funct3 = 3'b000; read_data2 = 32'hFFFF_FF00; #1;
    checks++; if (alu_branch !== 1'b0) begin errors++; $display("FAIL md_no_branch: got %b expected 0", alu_branch); end
    is_md = 0; #1;
    checks++; if (alu_branch !== 1'b1) begin errors++; $display("FAIL beq_branch: got %b expected 1", alu_branch); end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_forward();
    clear_inputs();
    rs2 = 5'd7; rd_mem = 5'd7; rd_wb = 5'd7; regwrite_mem = 1; regwrite_wb = 1;
    wb_data_mem = 32'hAAAA; write_data_wb = 32'hBBBB; read_data2 = 32'hCCCC; #1;
    checks++; if (read_data2_forwarded !== 32'hAAAA) begin errors++; $display("FAIL fwd_mem_prio: got %h expected %h", read_data2_forwarded, 32'hAAAA); end
    regwrite_mem = 0; #1;
    checks++; if (read_data2_forwarded !== 32'hBBBB) begin errors++; $display("FAIL fwd_wb: got %h expected %h", read_data2_forwarded, 32'hBBBB); end
    regwrite_wb = 0; #1;
    checks++; if (read_data2_forwarded !== 32'hCCCC) begin errors++; $display("FAIL fwd_regfile: got %h expected %h", read_data2_forwarded, 32'hCCCC); end
    rs2 = 0; rd_mem = 0; rd_wb = 0; regwrite_mem = 1; regwrite_wb = 1; #1;
    checks++; if (read_data2_forwarded !== 32'hCCCC) begin errors++; $display("FAIL fwd_x0: got %h expected %h", read_data2_forwarded, 32'hCCCC); end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat, st;
    run_md(3'b000, 32'd7, 32'hFFFF_FFFD, 0, 0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h expected %h", r, 32'hFFFF_FFEB); end
    checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    checks++; if (st != 33) begin errors++; $display("FAIL mul_stall_cycles: got %0d expected 33", st); end
    run_md(3'b001, 32'h8000_0000, 32'h8000_0000, 0, 0, r, lat, st);
    checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL mulh_result: got %h expected %h", r, 32'h4000_0000); end
    run_md(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_result: got %h expected %h", r, 32'hFFFF_FFFE); end
    run_md(3'b010, 32'hFFFF_FFFF, 32'd2, 0, 0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_result: got %h expected %h", r, 32'hFFFF_FFFF); end
  endtask

  task automatic test_bpc4();
    logic [31:0] r; int lat, st;
    run_md(3'b000, 32'd7, 32'hFFFF_FFFD, 1, 0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL bpc4_mul_result: got %h expected %h", r, 32'hFFFF_FFEB); end
    checks++; if (lat != 9) begin errors++; $display("FAIL bpc4_mul_latency: got %0d expected 9", lat); end
    run_md(3'b100, 32'hFFFF_FFF9, 32'd2, 1, 0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL bpc4_div_result: got %h expected %h", r, 32'hFFFF_FFFD); end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat, st;
    run_md(3'b100, 32'hFFFF_FFF9, 32'd2, 0, 0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_result: got %h expected %h", r, 32'hFFFF_FFFD); end
    checks++; if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end
    run_md(3'b110, 32'hFFFF_FFF9, 32'd2, 0, 0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_result: got %h expected %h", r, 32'hFFFF_FFFF); end
    run_md(3'b101, 32'd100, 32'd7, 0, 0, r, lat, st);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_result: got %h expected %h", r, 32'd14); end
    run_md(3'b111, 32'd100, 32'd7, 0, 0, r, lat, st);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_result: got %h expected %h", r, 32'd2); end
    run_md(3'b100, 32'd5, 32'd0, 0, 0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_result: got %h expected %h", r, 32'hFFFF_FFFF); end
    checks++; if (lat != 1) begin errors++; $display("FAIL div0_latency: got %0d expected 1", lat); end
    checks++; if (st != 1) begin errors++; $display("FAIL div0_stall_cycles: got %0d expected 1", st); end
    run_md(3'b111, 32'd5, 32'd0, 0, 0, r, lat, st);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL remu0_result: got %h expected %h", r, 32'd5); end
    run_md(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, r, lat, st);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL divovf_result: got %h expected %h", r, 32'h8000_0000); end
    checks++; if (lat != 1) begin errors++; $display("FAIL divovf_latency: got %0d expected 1", lat); end
    run_md(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, r, lat, st);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL removf_result: got %h expected %h", r, 32'h0); end
  endtask

  task automatic test_latch();
    logic [31:0] r; int lat, st;
    run_md(3'b000, 32'd6, 32'd7, 0, 1, r, lat, st);
    checks++; if (r !== 32'd42) begin errors++; $display("FAIL latch_fwd_mul: got %h expected %h", r, 32'd42); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; int l1, l2, st;
    run_md(3'b000, 32'd12, 32'd12, 0, 0, r1, l1, st);
    run_md(3'b101, 32'd144, 32'd5, 0, 0, r2, l2, st);
    checks++; if (r1 !== 32'd144) begin errors++; $display("FAIL b2b_first: got %h expected %h", r1, 32'd144); end
    checks++; if (r2 !== 32'd28 || l2 != 33) begin errors++; $display("FAIL b2b_second: got %h lat %0d expected %h lat 33", r2, l2, 32'd28); end
  endtask

  task automatic test_flush();
    int seen;
    clear_inputs();
    // flush together with accept: nothing starts
    in_valid = 1; is_md = 1; funct3 = 3'b000; read_data1 = 32'd7; read_data2 = 32'd3;
    rs1 = 5'd1; rs2 = 5'd2; flush = 1;
    @(negedge clk);
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL flush_accept_stall: got %b expected 0", ex_stall); end
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    @(negedge clk);
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL flush_accept_idle: got %b expected 0", ex_stall); end
    @(posedge clk); #1;
    // flush in BUSY at t+10
    in_valid = 1;
    for (int c = 1; c <= 10; c++) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL busy_stall: got %b expected 1", ex_stall); end
    flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    @(negedge clk);
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL flush_busy_stall: got %b expected 0", ex_stall); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin @(negedge clk); if (result_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_result: got %0d valid cycles expected 0", seen); end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat, st;
    clear_inputs();
    in_valid = 1; is_md = 1; funct3 = 3'b000; read_data1 = 32'd7; read_data2 = 32'hFFFF_FFFD;
    rs1 = 5'd1; rs2 = 5'd2; pc = 32'h40; immediate = 32'h4;
    for (int c = 1; c <= 5; c++) begin @(posedge clk); #1; end
    rst = 0; #1;
    checks++; if (ex_stall !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got stall %b valid %b expected 0 0", ex_stall, result_valid); end
    checks++; if (sum !== 32'h0 || alu_result !== 32'h0) begin errors++; $display("FAIL rst_mid_data: got sum %h result %h expected 0 0", sum, alu_result); end
    clear_inputs();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    run_md(3'b000, 32'd7, 32'hFFFF_FFFD, 0, 0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFEB || lat != 33) begin errors++; $display("FAIL rst_mid_rerun: got %h lat %0d expected %h lat 33", r, lat, 32'hFFFF_FFEB); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_misc();
    test_forward();
    test_mul();
    test_bpc4();
    test_div();
    test_latch();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
